// File: rtl/pong_pkg.sv
// pong_pkg: state encoding, BCD limit and default game parameters for the pong sequencer
package pong_pkg;
    localparam logic [1:0] ST_NEWGAME = 2'd0;
    localparam logic [1:0] ST_PLAY    = 2'd1;
    localparam logic [1:0] ST_NEWBALL = 2'd2;
    localparam logic [1:0] ST_OVER    = 2'd3;
    localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
    localparam int BALLS_INIT_DEF   = 3;
    localparam int TIMER_FRAMES_DEF = 120;
    typedef enum logic [1:0] {
        S_NEWGAME = ST_NEWGAME,
        S_PLAY    = ST_PLAY,
        S_NEWBALL = ST_NEWBALL,
        S_OVER    = ST_OVER
    } state_t;
endpackage

// File: rtl/pong_bcd_counter.sv
// pong_bcd_counter: 2-digit BCD counter, clear has priority over increment, wraps 99 -> 00
module pong_bcd_counter
    import pong_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [7:0] q
);
    logic [7:0] nxt;
    always_comb begin
        nxt = (q[3:0] == BCD_MAX_DIGIT)
            ? {(q[7:4] == BCD_MAX_DIGIT) ? 4'd0 : q[7:4] + 4'd1, 4'd0}
            : {q[7:4], q[3:0] + 4'd1};
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset)    q <= 8'h00;
        else if (clr) q <= 8'h00;
        else if (inc) q <= nxt;
    end
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game sequencer (NEWGAME/PLAY/NEWBALL/OVER), BCD score, ball count, frame timer.
// Optional high score register enabled by defining PONG_HISCORE_EN.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int BALLS_INIT   = BALLS_INIT_DEF,
    parameter int TIMER_FRAMES = TIMER_FRAMES_DEF,
    parameter int TIMER_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic [1:0] btn,
    input  logic       hit,
    input  logic       miss,
    output logic       still_graph,
    output logic [1:0] screen,
    output logic [7:0] score,
    output logic [2:0] balls_left,
    output logic [7:0] hiscore
);
    state_t state;
    logic [TIMER_W-1:0] timer;
    logic hit_d, miss_d;
    logic btn_any, hit_evt, miss_evt, last_ball;
    assign btn_any     = |btn;
    assign hit_evt     = hit & ~hit_d;
    assign miss_evt    = miss & ~miss_d;
    assign last_ball   = balls_left <= 3'd1;
    assign still_graph = state != S_PLAY;
    assign screen      = state;
    pong_bcd_counter u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (state == S_NEWGAME && btn_any),
        .inc   (state == S_PLAY && hit_evt && !miss_evt),
        .q     (score)
    );
    // the load on a miss is written last so it overrides a same-cycle frame_tick decrement
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_NEWGAME;
            balls_left <= 3'(BALLS_INIT);
            timer      <= '0;
            hit_d      <= 1'b0;
            miss_d     <= 1'b0;
        end else begin
            hit_d  <= hit;
            miss_d <= miss;
            if (frame_tick && timer != '0) timer <= timer - 1'b1;
            case (state)
                S_NEWGAME: if (btn_any) begin
                    state      <= S_PLAY;
                    balls_left <= 3'(BALLS_INIT);
                end
                S_PLAY: if (miss_evt) begin
                    state      <= last_ball ? S_OVER : S_NEWBALL;
                    balls_left <= balls_left - 3'd1;
                    timer      <= TIMER_W'(TIMER_FRAMES);
                end
                S_NEWBALL: if (timer == '0 && btn_any) state <= S_PLAY;
                S_OVER:    if (timer == '0) state <= S_NEWGAME;
            endcase
        end
    end
`ifdef PONG_HISCORE_EN
    // valid BCD orders the same as unsigned binary, so a plain compare is tens-then-units
    always_ff @(posedge clk or posedge reset) begin
        if (reset) hiscore <= 8'h00;
        else if (state == S_PLAY && miss_evt && last_ball && score > hiscore) hiscore <= score;
    end
`else
    assign hiscore = 8'h00;
`endif
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed stimulus with an integer-level game model checked every cycle
module tb_pong_game_ctrl;
`ifdef PONG_HISCORE_EN
    localparam bit HS = 1'b1;
`else
    localparam bit HS = 1'b0;
`endif
    localparam int BALLS = 3;
    localparam int FRAMES = 120;
    logic clk = 1'b0, reset = 1'b1, frame_tick = 1'b0, hit = 1'b0, miss = 1'b0;
    logic [1:0] btn = 2'b00;
    logic still_graph;
    logic [1:0] screen;
    logic [7:0] score, hiscore;
    logic [2:0] balls_left;
    int n_checks = 0, n_fail = 0;
    bit run = 1'b0;
    int m_state = 0, m_score = 0, m_balls = BALLS, m_timer = 0, m_hi = 0;
    bit m_hd = 1'b0, m_md = 1'b0;

    pong_game_ctrl dut (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn(btn), .hit(hit), .miss(miss),
        .still_graph(still_graph), .screen(screen), .score(score), .balls_left(balls_left),
        .hiscore(hiscore)
    );

    always #5 clk = ~clk;

    function automatic int bcd(input int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // game rules expressed on integers: score 0..99, balls count, frame countdown
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state = 0; m_score = 0; m_balls = BALLS; m_timer = 0; m_hi = 0;
            m_hd = 1'b0; m_md = 1'b0;
        end else begin
            automatic bit he = hit && !m_hd;
            automatic bit me = miss && !m_md;
            automatic bit b = btn != 2'b00;
            automatic int t0 = m_timer;
            if (frame_tick && m_timer > 0) m_timer--;
            if (m_state == 0) begin
                if (b) begin m_state = 1; m_score = 0; m_balls = BALLS; end
            end else if (m_state == 1) begin
                if (me) begin
                    m_balls--;
                    m_timer = FRAMES;
                    m_state = (m_balls == 0) ? 3 : 2;
                    if (m_state == 3 && HS && m_score > m_hi) m_hi = m_score;
                end else if (he) m_score = (m_score + 1) % 100;
            end else if (m_state == 2) begin
                if (t0 == 0 && b) m_state = 1;
            end else if (t0 == 0) m_state = 0;
            m_hd = hit; m_md = miss;
        end
    end

    always @(negedge clk) if (run) begin
        chk("screen", 32'(screen), 32'(m_state));
        chk("still_graph", 32'(still_graph), 32'(m_state != 1));
        chk("score", 32'(score), 32'(bcd(m_score)));
        chk("balls_left", 32'(balls_left), 32'(m_balls));
        chk("hiscore", 32'(hiscore), 32'(bcd(m_hi)));
    end

    task automatic step(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask
    task automatic hits(input int n);
        repeat (n) begin hit = 1'b1; step(); hit = 1'b0; step(); end
    endtask
    task automatic frames(input int n);
        repeat (n) begin frame_tick = 1'b1; step(); frame_tick = 1'b0; step(); end
    endtask
    task automatic start_game();
        btn = 2'b01; step(); btn = 2'b00;
    endtask
    task automatic miss_pulse();
        miss = 1'b1; step(); miss = 1'b0;
    endtask
    task automatic lose_ball();
        miss_pulse(); btn = 2'b10; frames(FRAMES); btn = 2'b00;
    endtask

    initial begin
        step(2); run = 1'b1; reset = 1'b0; step();
        chk("rst_screen", 32'(screen), 0);
        chk("rst_still", 32'(still_graph), 1);
        chk("rst_score", 32'(score), 32'h00);
        chk("rst_balls", 32'(balls_left), 3);
        chk("rst_hiscore", 32'(hiscore), 32'h00);
        start_game();
        chk("start_screen", 32'(screen), 1);
        chk("start_still", 32'(still_graph), 0);
        chk("start_balls", 32'(balls_left), 3);
        hit = 1'b1; step(40); hit = 1'b0; step();
        chk("held_hit_once", 32'(score), 32'h01);
        hits(7);
        chk("score_08", 32'(score), 32'h08);
        hits(3);
        chk("score_11", 32'(score), 32'h11);
        hits(89);
        chk("score_to_00", 32'(score), 32'h00);
        hits(100);
        chk("wrap_100", 32'(score), 32'h00);
        hits(99);
        chk("score_99", 32'(score), 32'h99);
        hits(1);
        chk("wrap_99_00", 32'(score), 32'h00);
        miss_pulse();
        chk("miss_screen", 32'(screen), 2);
        chk("miss_balls", 32'(balls_left), 2);
        chk("miss_still", 32'(still_graph), 1);
        hits(1);
        chk("newball_hit_ignored", 32'(score), 32'h00);
        btn = 2'b01; frames(FRAMES - 1);
        chk("newball_wait", 32'(screen), 2);
        frames(1); btn = 2'b00;
        chk("newball_release", 32'(screen), 1);
        hits(5);
        hit = 1'b1; miss = 1'b1; step(); hit = 1'b0; miss = 1'b0;
        chk("both_score", 32'(score), 32'h05);
        chk("both_balls", 32'(balls_left), 1);
        chk("both_screen", 32'(screen), 2);
        btn = 2'b01; frames(FRAMES); btn = 2'b00;
        miss_pulse();
        chk("over_screen", 32'(screen), 3);
        chk("over_balls", 32'(balls_left), 0);
        btn = 2'b11; frames(FRAMES - 1); btn = 2'b00;
        chk("over_btn_ignored", 32'(screen), 3);
        frames(1);
        chk("over_to_newgame", 32'(screen), 0);
        chk("over_score_kept", 32'(score), 32'h05);
        start_game();
        hits(12);
        lose_ball(); lose_ball(); miss_pulse();
        chk("hiscore_12", 32'(hiscore), HS ? 32'h12 : 32'h00);
        frames(FRAMES);
        start_game();
        hits(7);
        lose_ball(); lose_ball(); miss_pulse();
        chk("hiscore_keep", 32'(hiscore), HS ? 32'h12 : 32'h00);
        chk("game3_score", 32'(score), 32'h07);
        frames(FRAMES);
        start_game();
        hits(3);
        #2 reset = 1'b1; #1;
        chk("async_screen", 32'(screen), 0);
        chk("async_still", 32'(still_graph), 1);
        chk("async_score", 32'(score), 32'h00);
        chk("async_balls", 32'(balls_left), 3);
        chk("async_hiscore", 32'(hiscore), 32'h00);
        step(); reset = 1'b0; step(2);
        run = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
